// File: rtl/t5_dwb_ram.sv
// t5_dwb_ram: Wishbone-style data-memory responder for the t5_rv32i dwb_* port.
// Each accepted strobe gets a registered single-cycle ack after WAIT_CYCLES
// optional wait states. Writes merge byte lanes into the addressed word; reads
// return the full stored word. An illegal byte select still acks, with dwb_err.
// Optional build macro: T5_DWB_LFSR_WAIT_EN adds 0..3 pseudo-random wait
// states per transfer, taken from a 16-bit LFSR.
module t5_dwb_ram #(
  parameter int XLEN        = 32,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            sys_ena,
  input  logic [31:2]     dwb_adr,
  input  logic [XLEN-1:0] dwb_dto,
  input  logic [3:0]      dwb_sel,
  input  logic            dwb_stb,
  input  logic            dwb_wre,
  output logic            dwb_ack,
  output logic [XLEN-1:0] dwb_dti,
  output logic            dwb_err
);

  localparam int         DEPTH = 1 << AW;
  localparam logic [4:0] WC    = 5'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Byte selects a 32-bit core can legally issue: single bytes, aligned halves, full word.
  function automatic logic sel_legal(input logic [3:0] s);
    case (s)
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: sel_legal = 1'b1;
      default:                                  sel_legal = 1'b0;
    endcase
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_cnt;
  logic [4:0]      w_cnt_nxt;
  logic [4:0]      w_load;
  logic            w_commit;
  logic            w_sel_ok;
  logic            w_we;
  logic [AW-1:0]   w_idx;
  logic            r_ack;
  logic            r_err;
  logic [XLEN-1:0] r_dti;
  logic [XLEN-1:0] r_mem [0:DEPTH-1];

  // Upper address bits above the implemented depth alias onto the same words.
  assign w_idx    = dwb_adr[AW+1:2];
  assign w_sel_ok = sel_legal(dwb_sel);

`ifdef T5_DWB_LFSR_WAIT_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // LFSR advances every enabled cycle to jitter the wait count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_lfsr <= 16'hACE1;
    end else if (sys_ena) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_load = WC + {3'b000, r_lfsr[1:0]};
`else
  assign w_load = WC;
`endif

  // Next-state logic: decide when the transfer commits, counts down or aborts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dwb_stb) begin
          if (w_load == 5'd0) begin
            w_commit    = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_cnt_nxt   = w_load;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!dwb_stb) begin
          w_cnt_nxt   = 5'd0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 5'd1) begin
          w_cnt_nxt   = 5'd0;
          w_commit    = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt   = r_cnt - 5'd1;
        end
      end
      S_ACK: begin
        // Strobe is ignored here; a held strobe restarts from IDLE next cycle.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  // State and wait counter; everything freezes while the clock enable is low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else if (sys_ena) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Response registers: ack/err pulse on the commit edge, read data loaded on read commits.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dti <= '0;
    end else if (sys_ena) begin
      r_ack <= w_commit;
      r_err <= w_commit & ~w_sel_ok;
      if (w_commit && !dwb_wre) begin
        r_dti <= r_mem[w_idx];
      end
    end
  end

  // Reset is folded in so a strobe seen during reset can never write memory.
  assign w_we = sys_ena & ~sys_rst & w_commit & dwb_wre & w_sel_ok;

  // Byte-lane merge into the addressed word; memory contents are never reset.
  always_ff @(posedge sys_clk) begin
    if (w_we) begin
      for (int n = 0; n < 4; n++) begin
        if (dwb_sel[n]) begin
          r_mem[w_idx][8*n +: 8] <= dwb_dto[8*n +: 8];
        end
      end
    end
  end

  assign dwb_ack = r_ack;
  assign dwb_err = r_err;
  assign dwb_dti = r_dti;

endmodule
